// File: rtl/audio_sample_sequencer_if.sv
// Sample-rate handshake bundle between the sequencer, the audio_effects datapath
// and the downstream consumer of captured samples.
interface audio_sample_sequencer_if;
    logic        enable;
    logic [3:0]  control_in;
    logic [3:0]  control_out;
    logic        sample_end;
    logic        sample_req;
    logic [15:0] dut_audio;
    logic [15:0] audio_out;
    logic        audio_out_valid;
    logic        busy;
    logic        overrun;

    modport master (
        input  enable, control_in, dut_audio,
        output control_out, sample_end, sample_req, audio_out, audio_out_valid, busy, overrun
    );

    modport slave (
        output enable, control_in, dut_audio,
        input  control_out, sample_end, sample_req, audio_out, audio_out_valid, busy, overrun
    );
endinterface

// File: rtl/audio_sample_sequencer.sv
// Drives audio_effects once per audio sample: sample_end, a programmable gap, sample_req,
// then captures the result; control changes land on sample boundaries with a click-mute window.
module audio_sample_sequencer #(
    parameter int SAMPLE_DIV   = 2083,
    parameter int REQ_GAP      = 1,
    parameter int MUTE_SAMPLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    audio_sample_sequencer_if.master bus
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int GAP_W  = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;
    localparam int MUTE_W = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((REQ_GAP > 0) ? REQ_GAP - 1 : 0);
    localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE, S_END, S_GAP, S_REQ, S_WAIT, S_CAP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [MUTE_W-1:0]  mute_q, mute_d;
    logic [3:0]         control_q, control_d;
    logic [15:0]        audio_q, audio_d;
    logic               sample_end_q, sample_end_d;
    logic               sample_req_q, sample_req_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               tick;

    // Divider is parked at zero while disabled so the first enabled cycle ticks.
    always_comb begin
        tick = bus.enable && (div_q == '0);
        if (!bus.enable || div_q == DIV_LAST) div_d = '0;
        else                                  div_d = div_q + 1'b1;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: if (tick) state_d = S_END;
            S_END: begin
                if (REQ_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_REQ;
                else             gap_d   = gap_q - 1'b1;
            end
            S_REQ:   state_d = S_WAIT;
            S_WAIT:  state_d = S_CAP;
            S_CAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are decoded from the next state so they leave the flops aligned with the state.
    always_comb begin
        control_d    = control_q;
        mute_d       = mute_q;
        audio_d      = audio_q;
        overrun_d    = overrun_q | (tick && state_q != S_IDLE);
        sample_end_d = (state_d == S_END);
        sample_req_d = (state_d == S_REQ);
        valid_d      = (state_d == S_CAP);
        busy_d       = (state_d != S_IDLE);

        if (state_q == S_IDLE && tick && bus.control_in != control_q) begin
            control_d = bus.control_in;
            mute_d    = MUTE_LOAD;
        end

        if (state_q == S_WAIT) begin
            audio_d = (mute_q != '0) ? 16'h0000 : bus.dut_audio;
            if (mute_q != '0) mute_d = mute_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            gap_q        <= '0;
            mute_q       <= '0;
            control_q    <= '0;
            audio_q      <= '0;
            sample_end_q <= 1'b0;
            sample_req_q <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            gap_q        <= gap_d;
            mute_q       <= mute_d;
            control_q    <= control_d;
            audio_q      <= audio_d;
            sample_end_q <= sample_end_d;
            sample_req_q <= sample_req_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.control_out     = control_q;
    assign bus.sample_end      = sample_end_q;
    assign bus.sample_req      = sample_req_q;
    assign bus.audio_out       = audio_q;
    assign bus.audio_out_valid = valid_q;
    assign bus.busy            = busy_q;
    assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer across four parameter sets sharing clk and reset.
module tb_audio_sample_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_sample_sequencer_if bus_a ();
    audio_sample_sequencer_if bus_b ();
    audio_sample_sequencer_if bus_c ();
    audio_sample_sequencer_if bus_d ();

    audio_sample_sequencer #(.SAMPLE_DIV(16), .REQ_GAP(1), .MUTE_SAMPLES(2)) u_a (
        .clk(clk), .reset(reset), .bus(bus_a.master));
    audio_sample_sequencer #(.SAMPLE_DIV(8), .REQ_GAP(0), .MUTE_SAMPLES(0)) u_b (
        .clk(clk), .reset(reset), .bus(bus_b.master));
    audio_sample_sequencer #(.SAMPLE_DIV(12), .REQ_GAP(3), .MUTE_SAMPLES(4)) u_c (
        .clk(clk), .reset(reset), .bus(bus_c.master));
    audio_sample_sequencer #(.SAMPLE_DIV(4), .REQ_GAP(1), .MUTE_SAMPLES(0)) u_d (
        .clk(clk), .reset(reset), .bus(bus_d.master));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int which, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc(1);
            seen = (which == 0) ? bus_a.audio_out_valid : bus_c.audio_out_valid;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_end_a(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc(1);
            seen = bus_a.sample_end;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        int first_end, second_end, first_req, first_valid;
        int n_end, n_req, n_valid, n_busy;

        reset = 1'b1;
        bus_a.enable = 0; bus_a.control_in = '0; bus_a.dut_audio = '0;
        bus_b.enable = 0; bus_b.control_in = '0; bus_b.dut_audio = '0;
        bus_c.enable = 0; bus_c.control_in = '0; bus_c.dut_audio = '0;
        bus_d.enable = 0; bus_d.control_in = '0; bus_d.dut_audio = '0;
        cyc(3);

        check("rst_control_out", 32'(bus_a.control_out), 32'h0);
        check("rst_pulses", {29'd0, bus_a.sample_end, bus_a.sample_req, bus_a.audio_out_valid}, 32'h0);
        check("rst_audio_out", 32'(bus_a.audio_out), 32'h0);
        check("rst_busy_overrun", {30'd0, bus_a.busy, bus_a.overrun}, 32'h0);

        // Basic cadence, SAMPLE_DIV=16 REQ_GAP=1: enable rises in cycle 0.
        reset = 1'b0;
        bus_a.dut_audio = 16'h1234;
        bus_a.enable    = 1'b1;
        first_end = -1; second_end = -1; first_req = -1; first_valid = -1;
        n_end = 0; n_req = 0; n_valid = 0; n_busy = 0;
        for (int i = 1; i <= 320; i++) begin
            cyc(1);
            if (bus_a.sample_end) begin
                n_end++;
                if (first_end < 0) first_end = i;
                else if (second_end < 0) second_end = i;
            end
            if (bus_a.sample_req) begin
                n_req++;
                if (first_req < 0) first_req = i;
            end
            if (bus_a.audio_out_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = i;
            end
            if (bus_a.busy) n_busy++;
        end
        check("a_first_end_cycle", 32'(first_end), 32'd1);
        check("a_first_req_cycle", 32'(first_req), 32'd3);
        check("a_first_valid_cycle", 32'(first_valid), 32'd5);
        check("a_second_end_cycle", 32'(second_end), 32'd17);
        check("a_end_count", 32'(n_end), 32'd20);
        check("a_req_count", 32'(n_req), 32'd20);
        check("a_valid_count", 32'(n_valid), 32'd20);
        check("a_busy_cycles", 32'(n_busy), 32'd100);
        check("a_audio_passthru", 32'(bus_a.audio_out), 32'h1234);
        check("a_overrun_legal", 32'(bus_a.overrun), 32'h0);

        // Control change with MUTE_SAMPLES=2.
        bus_a.enable = 1'b0;
        do_reset();
        bus_a.control_in = 4'b0001;
        bus_a.dut_audio  = 16'hAAAA;
        bus_a.enable     = 1'b1;
        wait_valid(0, "m_valid0_timeout");
        check("m_control_first_tick", 32'(bus_a.control_out), 32'h1);
        check("m_sample0_muted", 32'(bus_a.audio_out), 32'h0);
        bus_a.dut_audio = 16'hBBBB;
        wait_valid(0, "m_valid1_timeout");
        check("m_sample1_muted", 32'(bus_a.audio_out), 32'h0);
        bus_a.dut_audio = 16'hCCCC;
        wait_valid(0, "m_valid2_timeout");
        check("m_sample2_live", 32'(bus_a.audio_out), 32'hCCCC);

        bus_a.control_in = 4'b0011;
        cyc(1);
        check("m_control_held_between_ticks", 32'(bus_a.control_out), 32'h1);
        wait_end_a("m_end_timeout");
        check("m_control_at_tick", 32'(bus_a.control_out), 32'h3);
        bus_a.dut_audio = 16'h1111;
        wait_valid(0, "m_valid3_timeout");
        check("m_sample3_muted", 32'(bus_a.audio_out), 32'h0);
        bus_a.dut_audio = 16'h2222;
        wait_valid(0, "m_valid4_timeout");
        check("m_sample4_muted", 32'(bus_a.audio_out), 32'h0);
        bus_a.dut_audio = 16'h3333;
        wait_valid(0, "m_valid5_timeout");
        check("m_sample5_live", 32'(bus_a.audio_out), 32'h3333);

        // Toggle back and forth inside one sample period: no reload.
        bus_a.control_in = 4'b0001;
        cyc(1);
        bus_a.control_in = 4'b0011;
        cyc(1);
        bus_a.dut_audio = 16'h4444;
        wait_valid(0, "m_valid6_timeout");
        check("m_toggle_no_mute", 32'(bus_a.audio_out), 32'h4444);
        check("m_toggle_control", 32'(bus_a.control_out), 32'h3);

        // Enable dropped while in GAP.
        bus_a.enable = 1'b0;
        do_reset();
        bus_a.control_in = 4'b0000;
        bus_a.enable     = 1'b1;
        cyc(1);
        check("e_end_cycle1", 32'(bus_a.sample_end), 32'h1);
        cyc(1);
        check("e_gap_busy", {30'd0, bus_a.busy, bus_a.sample_req}, 32'h2);
        bus_a.enable = 1'b0;
        n_end = 0; n_req = 0; n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            n_end   += int'(bus_a.sample_end);
            n_req   += int'(bus_a.sample_req);
            n_valid += int'(bus_a.audio_out_valid);
        end
        check("e_req_completes", 32'(n_req), 32'd1);
        check("e_valid_completes", 32'(n_valid), 32'd1);
        check("e_no_new_end", 32'(n_end), 32'd0);
        check("e_idle_after", 32'(bus_a.busy), 32'h0);
        bus_a.enable = 1'b1;
        cyc(1);
        check("e_reenable_end", 32'(bus_a.sample_end), 32'h1);

        // Reset pulsed in REQ.
        bus_a.enable = 1'b0;
        do_reset();
        bus_a.control_in = 4'b0101;
        bus_a.enable     = 1'b1;
        cyc(3);
        check("r_in_req", 32'(bus_a.sample_req), 32'h1);
        check("r_control_loaded", 32'(bus_a.control_out), 32'h5);
        reset        = 1'b1;
        bus_a.enable = 1'b0;
        cyc(1);
        reset = 1'b0;
        check("r_control_cleared", 32'(bus_a.control_out), 32'h0);
        check("r_pulses_cleared", {29'd0, bus_a.sample_end, bus_a.sample_req, bus_a.audio_out_valid}, 32'h0);
        check("r_busy_overrun", {30'd0, bus_a.busy, bus_a.overrun}, 32'h0);
        check("r_audio_cleared", 32'(bus_a.audio_out), 32'h0);
        n_end = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            n_end += int'(bus_a.sample_end) + int'(bus_a.sample_req) + int'(bus_a.audio_out_valid);
        end
        check("r_no_partial_pulses", 32'(n_end), 32'd0);

        // REQ_GAP=0.
        do_reset();
        bus_b.enable = 1'b1;
        first_end = -1; first_req = -1; first_valid = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (bus_b.sample_end && first_end < 0) first_end = i;
            if (bus_b.sample_req && first_req < 0) first_req = i;
            if (bus_b.audio_out_valid && first_valid < 0) first_valid = i;
        end
        check("g0_end_cycle", 32'(first_end), 32'd1);
        check("g0_req_cycle", 32'(first_req), 32'd2);
        check("g0_valid_cycle", 32'(first_valid), 32'd4);
        bus_b.enable = 1'b0;

        // REQ_GAP=3 with MUTE_SAMPLES=4 and SINE selected from the first tick.
        do_reset();
        bus_c.control_in = 4'b0001;
        bus_c.dut_audio  = 16'h0F0F;
        bus_c.enable     = 1'b1;
        first_end = -1; first_req = -1; first_valid = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (bus_c.sample_end && first_end < 0) first_end = i;
            if (bus_c.sample_req && first_req < 0) first_req = i;
            if (bus_c.audio_out_valid && first_valid < 0) first_valid = i;
        end
        check("g3_end_cycle", 32'(first_end), 32'd1);
        check("g3_req_cycle", 32'(first_req), 32'd5);
        check("g3_valid_cycle", 32'(first_valid), 32'd7);
        check("g3_control", 32'(bus_c.control_out), 32'h1);
        check("g3_mute0", 32'(bus_c.audio_out), 32'h0);
        wait_valid(1, "g3_valid1_timeout");
        check("g3_mute1", 32'(bus_c.audio_out), 32'h0);
        wait_valid(1, "g3_valid2_timeout");
        check("g3_mute2", 32'(bus_c.audio_out), 32'h0);
        wait_valid(1, "g3_valid3_timeout");
        check("g3_mute3", 32'(bus_c.audio_out), 32'h0);
        bus_c.dut_audio = 16'h5A5A;
        wait_valid(1, "g3_valid4_timeout");
        check("g3_live4", 32'(bus_c.audio_out), 32'h5A5A);

        // Illegal SAMPLE_DIV=4: tick lands while busy.
        do_reset();
        bus_d.enable = 1'b1;
        cyc(2);
        check("ov_initially_clear", 32'(bus_d.overrun), 32'h0);
        cyc(20);
        check("ov_set", 32'(bus_d.overrun), 32'h1);
        bus_d.enable = 1'b0;
        cyc(10);
        check("ov_sticky", 32'(bus_d.overrun), 32'h1);
        check("ov_legal_clear", 32'(bus_c.overrun), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
